// File: rtl/bp_cache_lce_mem_port_if.sv
// LCE-side memory-packet bundle: data/tag/stat request packets, yumi handshakes and read data.
// The LCE is the master; the cache-side responder uses the slave modport.
interface bp_cache_lce_mem_port_if #(
    parameter int unsigned sets_p        = 64,
    parameter int unsigned assoc_p       = 8,
    parameter int unsigned block_width_p = 512,
    parameter int unsigned ptag_width_p  = 28
);
    localparam int unsigned lg_sets  = $clog2(sets_p);
    localparam int unsigned lg_assoc = $clog2(assoc_p);
    localparam int unsigned tag_w    = ptag_width_p + 3;
    localparam int unsigned sw       = 2 * assoc_p - 1;

    logic                     data_pkt_v;
    logic                     data_pkt_w;
    logic [lg_sets-1:0]       data_pkt_index;
    logic [lg_assoc-1:0]      data_pkt_way;
    logic [block_width_p-1:0] data_pkt_data;
    logic                     data_pkt_yumi;
    logic [block_width_p-1:0] data_mem;

    logic                     tag_pkt_v;
    logic                     tag_pkt_w;
    logic [lg_sets-1:0]       tag_pkt_index;
    logic [lg_assoc-1:0]      tag_pkt_way;
    logic [tag_w-1:0]         tag_pkt_tag;
    logic                     tag_pkt_yumi;
    logic [tag_w-1:0]         tag_mem;

    logic                     stat_pkt_v;
    logic                     stat_pkt_op;
    logic [lg_sets-1:0]       stat_pkt_index;
    logic [lg_assoc-1:0]      stat_pkt_way;
    logic                     stat_pkt_yumi;
    logic [sw-1:0]            stat_mem;

    modport master (
        output data_pkt_v, data_pkt_w, data_pkt_index, data_pkt_way, data_pkt_data,
        input  data_pkt_yumi, data_mem,
        output tag_pkt_v, tag_pkt_w, tag_pkt_index, tag_pkt_way, tag_pkt_tag,
        input  tag_pkt_yumi, tag_mem,
        output stat_pkt_v, stat_pkt_op, stat_pkt_index, stat_pkt_way,
        input  stat_pkt_yumi, stat_mem
    );

    modport slave (
        input  data_pkt_v, data_pkt_w, data_pkt_index, data_pkt_way, data_pkt_data,
        output data_pkt_yumi, data_mem,
        input  tag_pkt_v, tag_pkt_w, tag_pkt_index, tag_pkt_way, tag_pkt_tag,
        output tag_pkt_yumi, tag_mem,
        input  stat_pkt_v, stat_pkt_op, stat_pkt_index, stat_pkt_way,
        output stat_pkt_yumi, stat_mem
    );
endinterface

// File: rtl/bp_cache_lce_mem_port.sv
// Cache-side responder for LCE memory packets: arbitrates LCE access to the data/tag/stat SRAMs
// against the pipeline, with a starvation bound, and holds read data until the next read.
module bp_cache_lce_mem_port #(
    parameter int unsigned sets_p         = 64,
    parameter int unsigned assoc_p        = 8,
    parameter int unsigned block_width_p  = 512,
    parameter int unsigned ptag_width_p   = 28,
    parameter int unsigned starve_limit_p = 4,
    localparam int unsigned lg_sets       = $clog2(sets_p),
    localparam int unsigned lg_assoc      = $clog2(assoc_p),
    localparam int unsigned tag_w         = ptag_width_p + 3,
    localparam int unsigned sw            = 2 * assoc_p - 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        tl_v_i,
    input  logic                        tv_v_i,
    input  logic [lg_sets-1:0]          tv_index_i,
    output logic                        stall_o,
    output logic                        replay_o,
    output logic                        lce_grant_o,

    bp_cache_lce_mem_port_if.slave      lce,

    output logic                        data_sram_v_o,
    output logic                        data_sram_w_o,
    output logic [lg_sets+lg_assoc-1:0] data_sram_addr_o,
    output logic [block_width_p-1:0]    data_sram_wdata_o,
    input  logic [block_width_p-1:0]    data_sram_i,

    output logic                        tag_sram_v_o,
    output logic                        tag_sram_w_o,
    output logic [lg_sets+lg_assoc-1:0] tag_sram_addr_o,
    output logic [tag_w-1:0]            tag_sram_wdata_o,
    input  logic [tag_w-1:0]            tag_sram_i,

    output logic                        stat_sram_v_o,
    output logic                        stat_sram_w_o,
    output logic [lg_sets-1:0]          stat_sram_addr_o,
    output logic [sw-1:0]               stat_sram_mask_o,
    input  logic [sw-1:0]               stat_sram_i
);
    localparam int unsigned cnt_w = $clog2(starve_limit_p + 1);
    localparam logic [cnt_w-1:0] starve_max = cnt_w'(starve_limit_p);

    logic [cnt_w-1:0]         starve_q, starve_d;
    logic                     any_v, grant, wr_hit;
    logic                     dpend_q, dpend_d, tpend_q, tpend_d, spend_q, spend_d;
    logic [block_width_p-1:0] dhold_q;
    logic [tag_w-1:0]         thold_q;
    logic [sw-1:0]            shold_q;

    always_comb begin
        any_v = lce.data_pkt_v | lce.tag_pkt_v | lce.stat_pkt_v;
        grant = ~reset_i & any_v & (~tl_v_i | (starve_q == starve_max));

        starve_d = starve_q;
        if (grant || !any_v) begin
            starve_d = '0;
        end else if (tl_v_i && (starve_q != starve_max)) begin
            starve_d = starve_q + 1'b1;
        end

        dpend_d = grant & lce.data_pkt_v & ~lce.data_pkt_w;
        tpend_d = grant & lce.tag_pkt_v & ~lce.tag_pkt_w;
        spend_d = grant & lce.stat_pkt_v & ~lce.stat_pkt_op;

        // Only writes disturb the set the pipeline is looking at in TV.
        wr_hit = grant & ((lce.data_pkt_v & lce.data_pkt_w & (lce.data_pkt_index == tv_index_i))
                        | (lce.tag_pkt_v & lce.tag_pkt_w & (lce.tag_pkt_index == tv_index_i))
                        | (lce.stat_pkt_v & lce.stat_pkt_op
                           & (lce.stat_pkt_index == tv_index_i)));
    end

    assign lce_grant_o = grant;
    assign stall_o     = grant & tl_v_i;
    assign replay_o    = tv_v_i & wr_hit;

    assign lce.data_pkt_yumi = lce.data_pkt_v & grant;
    assign lce.tag_pkt_yumi  = lce.tag_pkt_v & grant;
    assign lce.stat_pkt_yumi = lce.stat_pkt_v & grant;

    assign data_sram_v_o     = lce.data_pkt_yumi;
    assign data_sram_w_o     = lce.data_pkt_w;
    assign data_sram_addr_o  = {lce.data_pkt_index, lce.data_pkt_way};
    assign data_sram_wdata_o = lce.data_pkt_data;

    assign tag_sram_v_o      = lce.tag_pkt_yumi;
    assign tag_sram_w_o      = lce.tag_pkt_w;
    assign tag_sram_addr_o   = {lce.tag_pkt_index, lce.tag_pkt_way};
    assign tag_sram_wdata_o  = lce.tag_pkt_tag;

    // Stat clear writes zero into the dirty bit of the selected way only.
    assign stat_sram_v_o     = lce.stat_pkt_yumi;
    assign stat_sram_w_o     = lce.stat_pkt_op;
    assign stat_sram_addr_o  = lce.stat_pkt_index;
    assign stat_sram_mask_o  = lce.stat_pkt_op ? (sw'(1) << (assoc_p - 1 + lce.stat_pkt_way))
                                               : '0;

    assign lce.data_mem = dpend_q ? data_sram_i : dhold_q;
    assign lce.tag_mem  = tpend_q ? tag_sram_i : thold_q;
    assign lce.stat_mem = spend_q ? stat_sram_i : shold_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q <= '0;
            dpend_q  <= 1'b0;
            tpend_q  <= 1'b0;
            spend_q  <= 1'b0;
            dhold_q  <= '0;
            thold_q  <= '0;
            shold_q  <= '0;
        end else begin
            starve_q <= starve_d;
            dpend_q  <= dpend_d;
            tpend_q  <= tpend_d;
            spend_q  <= spend_d;
            if (dpend_q) dhold_q <= data_sram_i;
            if (tpend_q) thold_q <= tag_sram_i;
            if (spend_q) shold_q <= stat_sram_i;
        end
    end
endmodule

// File: tb/tb_bp_cache_lce_mem_port.sv
// Self-checking bench for bp_cache_lce_mem_port: directed table, hand sequences and a random
// phase, all compared against a cycle-level behavioural model of the arbitration rules.
module tb_bp_cache_lce_mem_port;
    localparam int SETS = 64, ASSOC = 8, BW = 512, PT = 28, LIM = 4;
    localparam int LGS = 6, LGA = 3, TW = PT + 3, SW = 2 * ASSOC - 1, AW = LGS + LGA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, tl_v, tv_v, stall, replay, grant;
    logic [LGS-1:0] tv_index;
    logic           data_sram_v, data_sram_w, tag_sram_v, tag_sram_w, stat_sram_v, stat_sram_w;
    logic [AW-1:0]  data_sram_addr, tag_sram_addr;
    logic [LGS-1:0] stat_sram_addr;
    logic [BW-1:0]  data_sram_wdata, data_sram_rdata;
    logic [TW-1:0]  tag_sram_wdata, tag_sram_rdata;
    logic [SW-1:0]  stat_sram_mask, stat_sram_rdata;

    bp_cache_lce_mem_port_if #(.sets_p(SETS), .assoc_p(ASSOC), .block_width_p(BW),
                               .ptag_width_p(PT)) lce ();

    bp_cache_lce_mem_port #(.sets_p(SETS), .assoc_p(ASSOC), .block_width_p(BW),
                            .ptag_width_p(PT), .starve_limit_p(LIM)) dut (
        .clk_i(clk), .reset_i(reset), .tl_v_i(tl_v), .tv_v_i(tv_v), .tv_index_i(tv_index),
        .stall_o(stall), .replay_o(replay), .lce_grant_o(grant), .lce(lce),
        .data_sram_v_o(data_sram_v), .data_sram_w_o(data_sram_w),
        .data_sram_addr_o(data_sram_addr), .data_sram_wdata_o(data_sram_wdata),
        .data_sram_i(data_sram_rdata),
        .tag_sram_v_o(tag_sram_v), .tag_sram_w_o(tag_sram_w),
        .tag_sram_addr_o(tag_sram_addr), .tag_sram_wdata_o(tag_sram_wdata),
        .tag_sram_i(tag_sram_rdata),
        .stat_sram_v_o(stat_sram_v), .stat_sram_w_o(stat_sram_w),
        .stat_sram_addr_o(stat_sram_addr), .stat_sram_mask_o(stat_sram_mask),
        .stat_sram_i(stat_sram_rdata)
    );

    int checks = 0, errors = 0;

    // Model state: contended cycles seen, "read granted last cycle" flags, last captured data.
    int            starve_m = 0;
    logic          dcap = 1'b0, tcap = 1'b0, scap = 1'b0, g_last = 1'b0;
    logic [BW-1:0] dheld = '0;
    logic [TW-1:0] theld = '0;
    logic [SW-1:0] sheld = '0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Mid-cycle: compare every output against the model, then advance the model.
    task automatic mid();
        logic any, g, hit, dv, tv, sv;
        logic [SW-1:0] m;
        @(negedge clk);
        dv  = lce.data_pkt_v;
        tv  = lce.tag_pkt_v;
        sv  = lce.stat_pkt_v;
        any = dv | tv | sv;
        g   = !reset && any && (!tl_v || starve_m >= LIM);
        hit = (dv && lce.data_pkt_w && lce.data_pkt_index == tv_index)
            || (tv && lce.tag_pkt_w && lce.tag_pkt_index == tv_index)
            || (sv && lce.stat_pkt_op && lce.stat_pkt_index == tv_index);
        chk("grant", BW'(grant), BW'(g));
        chk("stall", BW'(stall), BW'(g && tl_v));
        chk("replay", BW'(replay), BW'(g && tv_v && hit));
        chk("data_yumi", BW'(lce.data_pkt_yumi), BW'(g && dv));
        chk("tag_yumi", BW'(lce.tag_pkt_yumi), BW'(g && tv));
        chk("stat_yumi", BW'(lce.stat_pkt_yumi), BW'(g && sv));
        chk("data_sram_v", BW'(data_sram_v), BW'(g && dv));
        chk("tag_sram_v", BW'(tag_sram_v), BW'(g && tv));
        chk("stat_sram_v", BW'(stat_sram_v), BW'(g && sv));
        if (g && dv) begin
            chk("data_sram_w", BW'(data_sram_w), BW'(lce.data_pkt_w));
            chk("data_sram_addr", BW'(data_sram_addr),
                BW'(lce.data_pkt_index * ASSOC + lce.data_pkt_way));
            if (lce.data_pkt_w) chk("data_sram_wdata", data_sram_wdata, lce.data_pkt_data);
        end
        if (g && tv) begin
            chk("tag_sram_w", BW'(tag_sram_w), BW'(lce.tag_pkt_w));
            chk("tag_sram_addr", BW'(tag_sram_addr),
                BW'(lce.tag_pkt_index * ASSOC + lce.tag_pkt_way));
            if (lce.tag_pkt_w) chk("tag_sram_wdata", BW'(tag_sram_wdata), BW'(lce.tag_pkt_tag));
        end
        if (g && sv) begin
            chk("stat_sram_w", BW'(stat_sram_w), BW'(lce.stat_pkt_op));
            chk("stat_sram_addr", BW'(stat_sram_addr), BW'(lce.stat_pkt_index));
            if (lce.stat_pkt_op) begin
                m = '0;
                m[ASSOC-1+int'(lce.stat_pkt_way)] = 1'b1;
                chk("stat_sram_mask", BW'(stat_sram_mask), BW'(m));
            end
        end
        chk("data_mem", lce.data_mem, dcap ? data_sram_rdata : dheld);
        chk("tag_mem", BW'(lce.tag_mem), BW'(tcap ? tag_sram_rdata : theld));
        chk("stat_mem", BW'(lce.stat_mem), BW'(scap ? stat_sram_rdata : sheld));
        if (reset) begin
            starve_m = 0;
            {dcap, tcap, scap} = 3'b000;
            dheld = '0;
            theld = '0;
            sheld = '0;
        end else begin
            if (dcap) dheld = data_sram_rdata;
            if (tcap) theld = tag_sram_rdata;
            if (scap) sheld = stat_sram_rdata;
            dcap = g && dv && !lce.data_pkt_w;
            tcap = g && tv && !lce.tag_pkt_w;
            scap = g && sv && !lce.stat_pkt_op;
            if (g || !any) starve_m = 0;
            else if (starve_m < LIM) starve_m++;
        end
        g_last = g;
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        mid();
        fin();
    endtask

    task automatic idle();
        lce.data_pkt_v = 1'b0;
        lce.tag_pkt_v  = 1'b0;
        lce.stat_pkt_v = 1'b0;
        tl_v = 1'b0;
        tv_v = 1'b0;
    endtask

    task automatic set_data(input logic w, input int ix);
        lce.data_pkt_v     = 1'b1;
        lce.data_pkt_w     = w;
        lce.data_pkt_index = LGS'(ix);
        lce.data_pkt_way   = LGA'($urandom);
        lce.data_pkt_data  = {16{$urandom}};
    endtask

    task automatic set_tag(input logic w, input int ix);
        lce.tag_pkt_v     = 1'b1;
        lce.tag_pkt_w     = w;
        lce.tag_pkt_index = LGS'(ix);
        lce.tag_pkt_way   = LGA'($urandom);
        lce.tag_pkt_tag   = TW'($urandom);
    endtask

    task automatic set_stat(input logic op, input int ix);
        lce.stat_pkt_v     = 1'b1;
        lce.stat_pkt_op    = op;
        lce.stat_pkt_index = LGS'(ix);
        lce.stat_pkt_way   = LGA'($urandom);
    endtask

    typedef struct {
        logic tl, tvv; int tvix;
        logic dv, dw;  int dix;
        logic tgv, tgw; int tix;
        logic sv, sop; int six;
        logic yd, yt, ys, st, rp;
    } vec_t;

    function automatic vec_t mk(input logic tl, tvv, input int tvix, input logic dv, dw,
                                input int dix, input logic tgv, tgw, input int tix,
                                input logic sv, sop, input int six,
                                input logic yd, yt, ys, st, rp);
        vec_t v;
        v.tl = tl;   v.tvv = tvv; v.tvix = tvix;
        v.dv = dv;   v.dw = dw;   v.dix = dix;
        v.tgv = tgv; v.tgw = tgw; v.tix = tix;
        v.sv = sv;   v.sop = sop; v.six = six;
        v.yd = yd;   v.yt = yt;   v.ys = ys;   v.st = st; v.rp = rp;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got running, expected finished");
        $fatal(1);
    end

    vec_t vecs[10];
    logic [SW-1:0] s_val;
    logic [BW-1:0] d_val;
    logic [TW-1:0] t_val;

    initial begin
        //          tl tvv tvix dv dw dix tgv tgw tix sv sop six  yd yt ys st rp
        vecs[0] = mk(0, 0, 0,   1, 0, 3,  0, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0);
        vecs[1] = mk(1, 0, 0,   1, 1, 3,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0);
        vecs[2] = mk(0, 1, 4,   0, 0, 0,  1, 1, 4,  0, 0, 0,   0, 1, 0, 0, 1);
        vecs[3] = mk(0, 1, 4,   0, 0, 0,  1, 1, 5,  0, 0, 0,   0, 1, 0, 0, 0);
        vecs[4] = mk(0, 0, 4,   0, 0, 0,  0, 0, 0,  1, 1, 4,   0, 0, 1, 0, 0);
        vecs[5] = mk(0, 1, 4,   0, 0, 0,  0, 0, 0,  1, 1, 4,   0, 0, 1, 0, 1);
        vecs[6] = mk(0, 1, 2,   0, 0, 0,  0, 0, 0,  1, 0, 2,   0, 0, 1, 0, 0);
        vecs[7] = mk(0, 1, 1,   1, 1, 1,  1, 0, 1,  1, 0, 1,   1, 1, 1, 0, 1);
        vecs[8] = mk(1, 1, 1,   1, 1, 1,  1, 1, 1,  1, 1, 1,   0, 0, 0, 0, 0);
        vecs[9] = mk(1, 1, 1,   0, 0, 0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0);

        reset = 1'b1;
        idle();
        tv_index = '0;
        set_data(1'b0, 0);
        set_tag(1'b0, 0);
        set_stat(1'b0, 0);
        data_sram_rdata = '0;
        tag_sram_rdata  = '0;
        stat_sram_rdata = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_grant", BW'(grant), '0);
        chk("rst_yumis", BW'({lce.data_pkt_yumi, lce.tag_pkt_yumi, lce.stat_pkt_yumi}), '0);
        chk("rst_sram_v", BW'({data_sram_v, tag_sram_v, stat_sram_v}), '0);
        chk("rst_stall_replay", BW'({stall, replay}), '0);
        fin();
        reset = 1'b0;
        idle();
        mid();
        chk("rst_data_mem", lce.data_mem, '0);
        chk("rst_tag_mem", BW'(lce.tag_mem), '0);
        chk("rst_stat_mem", BW'(lce.stat_mem), '0);
        fin();

        for (int i = 0; i < 10; i++) begin
            tl_v = vecs[i].tl;
            tv_v = vecs[i].tvv;
            tv_index = LGS'(vecs[i].tvix);
            if (vecs[i].dv) set_data(vecs[i].dw, vecs[i].dix);
            if (vecs[i].tgv) set_tag(vecs[i].tgw, vecs[i].tix);
            if (vecs[i].sv) set_stat(vecs[i].sop, vecs[i].six);
            mid();
            chk($sformatf("vec%0d_yumi", i),
                BW'({lce.data_pkt_yumi, lce.tag_pkt_yumi, lce.stat_pkt_yumi}),
                BW'({vecs[i].yd, vecs[i].yt, vecs[i].ys}));
            chk($sformatf("vec%0d_stall", i), BW'(stall), BW'(vecs[i].st));
            chk($sformatf("vec%0d_replay", i), BW'(replay), BW'(vecs[i].rp));
            fin();
            idle();
            step();
        end

        // Tag read: data returned the next cycle and held across idle cycles.
        set_tag(1'b0, 5);
        lce.tag_pkt_way = 3'd2;
        mid();
        chk("tagrd_yumi", BW'(lce.tag_pkt_yumi), BW'(1));
        chk("tagrd_addr", BW'(tag_sram_addr), BW'(5 * 8 + 2));
        fin();
        idle();
        tag_sram_rdata = TW'(32'h1ABCDEF);
        mid();
        chk("tagrd_data", BW'(lce.tag_mem), BW'(32'h1ABCDEF));
        fin();
        for (int i = 0; i < 3; i++) begin
            tag_sram_rdata = TW'($urandom);
            mid();
            chk("tagrd_hold", BW'(lce.tag_mem), BW'(32'h1ABCDEF));
            fin();
        end

        // Starvation: four contended cycles, forced through on the fifth.
        tl_v = 1'b1;
        set_data(1'b1, 1);
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("starve_yumi", BW'(lce.data_pkt_yumi), BW'(c == 4));
            if (c == 4) begin
                chk("starve_stall", BW'(stall), BW'(1));
                chk("starve_w", BW'(data_sram_w), BW'(1));
            end
            fin();
        end
        set_data(1'b1, 2);
        mid();
        chk("starve_cleared", BW'(lce.data_pkt_yumi), '0);
        fin();
        idle();
        step();

        // Stat clear leaves the held stat read data alone.
        s_val = SW'($urandom);
        set_stat(1'b0, 7);
        step();
        idle();
        stat_sram_rdata = s_val;
        step();
        set_stat(1'b1, 7);
        lce.stat_pkt_way = 3'd3;
        stat_sram_rdata = ~s_val;
        mid();
        chk("clr_mask", BW'(stat_sram_mask), BW'(1 << 10));
        chk("clr_w", BW'(stat_sram_w), BW'(1));
        chk("clr_mem", BW'(lce.stat_mem), BW'(s_val));
        fin();
        idle();
        mid();
        chk("clr_mem_after", BW'(lce.stat_mem), BW'(s_val));
        fin();

        // Replay: forced write to the TV set, a write to another set, a read to the TV set.
        tl_v = 1'b1;
        tv_v = 1'b1;
        tv_index = LGS'(9);
        set_data(1'b1, 9);
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("replay_forced", BW'(replay), BW'(c == 4));
            fin();
        end
        tl_v = 1'b0;
        tv_index = LGS'(10);
        mid();
        chk("replay_other_set", BW'(replay), '0);
        fin();
        idle();
        tv_v = 1'b1;
        tv_index = LGS'(9);
        set_tag(1'b0, 9);
        mid();
        chk("replay_read", BW'(replay), '0);
        fin();
        idle();
        step();

        // All three reads granted together.
        set_data(1'b0, 11);
        set_tag(1'b0, 12);
        set_stat(1'b0, 13);
        mid();
        chk("tri_yumi", BW'({lce.data_pkt_yumi, lce.tag_pkt_yumi, lce.stat_pkt_yumi}), BW'(7));
        fin();
        idle();
        d_val = {16{$urandom}};
        t_val = TW'($urandom);
        s_val = SW'($urandom);
        data_sram_rdata = d_val;
        tag_sram_rdata  = t_val;
        stat_sram_rdata = s_val;
        mid();
        chk("tri_data", lce.data_mem, d_val);
        chk("tri_tag", BW'(lce.tag_mem), BW'(t_val));
        chk("tri_stat", BW'(lce.stat_mem), BW'(s_val));
        fin();

        // Reset right after a data read grant discards that read.
        set_data(1'b0, 2);
        mid();
        chk("rstrd_yumi", BW'(lce.data_pkt_yumi), BW'(1));
        fin();
        reset = 1'b1;
        tl_v = 1'b1;
        data_sram_rdata = {16{$urandom}};
        mid();
        chk("rstrd_no_yumi", BW'(lce.data_pkt_yumi), '0);
        fin();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mid();
            if (c == 0) chk("rstrd_data_mem", lce.data_mem, '0);
            chk("rstrd_starve", BW'(lce.data_pkt_yumi), BW'(c == 4));
            fin();
        end
        idle();
        step();

        // Random traffic; packets stay stable until consumed.
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            tl_v  = ($urandom_range(0, 9) < 6);
            tv_v  = 1'($urandom_range(0, 1));
            tv_index = LGS'($urandom_range(0, 3));
            if (!lce.data_pkt_v && $urandom_range(0, 2) == 0)
                set_data(1'($urandom), $urandom_range(0, 3));
            if (!lce.tag_pkt_v && $urandom_range(0, 2) == 0)
                set_tag(1'($urandom), $urandom_range(0, 3));
            if (!lce.stat_pkt_v && $urandom_range(0, 2) == 0)
                set_stat(1'($urandom), $urandom_range(0, 3));
            data_sram_rdata = {16{$urandom}};
            tag_sram_rdata  = TW'($urandom);
            stat_sram_rdata = SW'($urandom);
            mid();
            fin();
            if (g_last) begin
                lce.data_pkt_v = 1'b0;
                lce.tag_pkt_v  = 1'b0;
                lce.stat_pkt_v = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_cache_lce_mem_port.md
# bp_cache_lce_mem_port

Cache-side responder for the LCE memory-packet interface. It accepts data, tag and stat packets from the LCE on valid->yumi handshakes, arbitrates them against the cache pipeline for the data, tag and stat SRAMs, and drives those SRAMs. Read data goes back to the LCE the cycle after yumi and is held stable until the next read. The block sits inside each L1 cache between the LCE and the cache's SRAM port muxes. It guarantees that the LCE is never starved by a continuously busy pipeline.

## Interface
- sets_p, 64: cache sets (power of two, >1); lg_sets = log2(sets_p)
- assoc_p, 8: ways (power of two); lg_assoc = log2(assoc_p)
- block_width_p, 512: data block width
- ptag_width_p, 28: physical tag width; tag word = {state[2:0], ptag}
- starve_limit_p, 4: contended cycles before the LCE is forced through; stat word width sw = 2*assoc_p-1
- clk_i  in  1  clock
- reset_i  in  1  reset, synchronous, active-high
- tl_v_i  in  1  pipeline claims all three SRAMs this cycle
- tv_v_i, tv_index_i  in  1, lg_sets  pipeline has a valid access in TV stage, and its set
- stall_o  out  1  pipeline must hold: LCE forced access this cycle
- replay_o  out  1  LCE write hit the TV-stage set; pipeline must replay the TV access
- lce_grant_o  out  1  SRAM port muxes select this block this cycle
- data_pkt_v_i, data_pkt_w_i  in  1, 1  data packet valid, write
- data_pkt_index_i, data_pkt_way_i  in  lg_sets, lg_assoc  target set/way
- data_pkt_data_i  in  block_width_p  write data
- data_pkt_yumi_o  out  1  packet consumed
- data_mem_o  out  block_width_p  read data
- tag_pkt_v_i, tag_pkt_w_i  in  1, 1  tag packet valid, write
- tag_pkt_index_i, tag_pkt_way_i  in  lg_sets, lg_assoc  target
- tag_pkt_tag_i  in  ptag_width_p+3  {state, ptag} write data
- tag_pkt_yumi_o  out  1  consumed
- tag_mem_o  out  ptag_width_p+3  read data
- stat_pkt_v_i, stat_pkt_op_i  in  1, 1  valid; op 0 = read, 1 = clear dirty of way
- stat_pkt_index_i, stat_pkt_way_i  in  lg_sets, lg_assoc  target
- stat_pkt_yumi_o  out  1  consumed
- stat_mem_o  out  sw  read data, {dirty[assoc_p-1:0], lru[assoc_p-2:0]}
- data_sram_v_o, data_sram_w_o, data_sram_addr_o, data_sram_wdata_o  out  1, 1, lg_sets+lg_assoc, block_width_p  data SRAM port, addr = {index, way}
- data_sram_i  in  block_width_p  sync-read data, valid the cycle after read
- tag_sram_v_o, tag_sram_w_o, tag_sram_addr_o, tag_sram_wdata_o  out  1, 1, lg_sets+lg_assoc, ptag_width_p+3  tag SRAM port
- tag_sram_i  in  ptag_width_p+3  sync-read data
- stat_sram_v_o, stat_sram_w_o, stat_sram_addr_o, stat_sram_mask_o  out  1, 1, lg_sets, sw  stat SRAM port; write data is always 0
- stat_sram_i  in  sw  sync-read data

## Operation
- any_v = data_pkt_v_i | tag_pkt_v_i | stat_pkt_v_i.
- Starvation counter starve_r (0..starve_limit_p, saturating):
  - Increments when any_v & tl_v_i & ~lce_grant_o.
  - Clears whenever lce_grant_o or ~any_v.
- lce_grant_o = any_v & (~tl_v_i | starve_r == starve_limit_p).
- stall_o = lce_grant_o & tl_v_i.
- All valid packets are granted together: X_pkt_yumi_o = X_pkt_v_i & lce_grant_o.
- SRAM outputs follow the granted packets:
  - X_sram_v_o = X_pkt_yumi_o.
  - Write flag and address come from the packet fields.
  - Stat clear: stat_sram_w_o=1, mask has only bit (assoc_p-1+way) set.
- Read capture:
  - Pending flags dpend_r, tpend_r, spend_r are set on a granted read and cleared otherwise.
  - Hold registers load X_sram_i when the corresponding pending flag is 1.
  - X_mem_o = pend_r ? X_sram_i : hold_r.
- Writes (data write, tag write, stat clear) never change hold registers.
- replay_o = tv_v_i & (granted write whose index == tv_index_i). Reads never cause replay.

## Timing
- Reset values: starve_r=0, pend flags=0, hold registers=0, so all X_mem_o=0. While reset_i=1, all yumi, *_sram_v_o, stall_o, replay_o and lce_grant_o are 0.
- yumi is combinational from the valid inputs and tl_v_i; it never depends on data fields.
- Read latency: read data appears on X_mem_o the cycle after yumi and stays stable until the cycle after the next granted read of that memory.
- Worst-case grant latency: starve_limit_p+1 cycles after valid rises under continuous tl_v_i.
- Once valid is asserted, the LCE holds a packet stable until yumi; this block does not re-check.
- A reset asserted the cycle after a read grant clears pending; that read's data is discarded.
- Back-to-back grants are allowed every cycle. A read followed immediately by a write in the next cycle keeps the read data.

## Test plan
- tl_v_i=0, tag read set 5 way 2, SRAM returns 0x1ABCDEF -> yumi same cycle; tag_mem_o=0x1ABCDEF the next cycle and held through 3 idle cycles.
- tl_v_i=1 continuously, data write pending, starve_limit_p=4 -> no yumi for 4 cycles; 5th cycle yumi=1, stall_o=1, data_sram_w_o=1; starve_r back to 0.
- Stat clear, way 3, assoc 8 -> stat_sram_mask_o = 1<<10, w=1, wdata 0; stat_mem_o unchanged.
- Forced data write to set 9 with tv_v_i=1, tv_index_i=9 -> replay_o=1. Same with tv_index_i=10 -> replay_o=0. A tag read to set 9 -> replay_o=0.
- Data, tag and stat reads valid together with tl_v_i=0 -> all three yumis in one cycle; all three X_mem_o update next cycle.
- Reset asserted the cycle after a data read grant -> data_mem_o=0 after reset, starve_r=0, no yumi while reset_i=1.
